// File: rtl/ddr4_writer_state_update.sv
// ddr4_writer_state_update
// Writes the Kalman filter's updated state X_kk and covariance P_kk back to
// DDR4 through a 512-bit AXI write port, one single-beat burst at a time.
// Both arrays are snapshotted when start is accepted, so the upstream stage
// may change them while the write-back runs. X beats go first, then the
// row-major P beats, eight 64-bit elements per beat. Lanes past the end of
// an array carry zero data and zero strobes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               level request, sampled only in IDLE
//   X_kk, P_kk          state vector / covariance [row][col], 64-bit elements
//   axi_aw*             write address channel (single beat, INCR, 64 B)
//   axi_w*              write data channel (wlast always 1)
//   axi_b*              write response channel
//   busy, done          status; done is a level held until start drops
//   wr_error            sticky bad-response flag
//
// Optional feature: define KALMAN_WR_BRESP_CHECK_EN to flag a non-OKAY bresp
// in wr_error and skip the remaining beats. Without it bresp is ignored and
// wr_error stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; snapshot arrays and load beat 0 on start
// ADDR_DATA | awvalid/wvalid offered, each held until its own handshake
// WAIT_B    | bready high, waiting for the write response of this beat
// DONE      | done high, waiting for start to drop

module ddr4_writer_state_update #(
    parameter int          STATE_DIM     = 12,
    parameter logic [31:0] ADDR_XKK_BASE = 32'h0050_0000,
    parameter logic [31:0] ADDR_PKK_BASE = 32'h0060_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  X_kk [STATE_DIM],
    input  logic [63:0]  P_kk [STATE_DIM][STATE_DIM],
    output logic [31:0]  axi_awaddr,
    output logic [7:0]   axi_awlen,
    output logic [2:0]   axi_awsize,
    output logic [1:0]   axi_awburst,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [511:0] axi_wdata,
    output logic [63:0]  axi_wstrb,
    output logic         axi_wlast,
    output logic         axi_wvalid,
    input  logic         axi_wready,
    input  logic [1:0]   axi_bresp,
    input  logic         axi_bvalid,
    output logic         axi_bready,
    output logic         busy,
    output logic         done,
    output logic         wr_error
);

    localparam int X_BEATS     = (STATE_DIM + 7) / 8;
    localparam int P_BEATS     = (STATE_DIM * STATE_DIM + 7) / 8;
    localparam int TOTAL_BEATS = X_BEATS + P_BEATS;
    localparam int BEAT_W      = $clog2(TOTAL_BEATS);
    localparam int IDX_W       = $clog2(STATE_DIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR_DATA,
        S_WAIT_B,
        S_DONE
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic              aw_done;
    logic              w_done;
    logic [63:0]       x_snap [STATE_DIM];
    logic [63:0]       p_snap [STATE_DIM][STATE_DIM];

    logic [63:0]       x_src [STATE_DIM];
    int                nxt_beat;
    int                lin;
    logic [31:0]       nxt_addr;
    logic [511:0]      nxt_wdata;
    logic [63:0]       nxt_wstrb;
    logic              aw_hs;
    logic              w_hs;
    logic              last_beat;
    logic              bresp_err;

    assign axi_awlen   = 8'd0;
    assign axi_awsize  = 3'b110;
    assign axi_awburst = 2'b01;
    assign axi_wlast   = 1'b1;

    assign aw_hs     = axi_awvalid && axi_awready;
    assign w_hs      = axi_wvalid && axi_wready;
    assign last_beat = (beat_cnt == BEAT_W'(TOTAL_BEATS - 1));

`ifdef KALMAN_WR_BRESP_CHECK_EN
    assign bresp_err = (axi_bresp != 2'b00);
`else
    logic unused_bresp;
    assign unused_bresp = ^axi_bresp;
    assign bresp_err    = 1'b0;
`endif

    // Beat 0 is built straight from the inputs in IDLE because the snapshot
    // registers are only written on that same edge.
    always_comb begin
        x_src = x_snap;
        if (state == S_IDLE) begin
            x_src = X_kk;
        end
        nxt_beat  = (state == S_IDLE) ? 0 : int'(beat_cnt) + 1;
        lin       = 0;
        nxt_wdata = '0;
        nxt_wstrb = '0;
        if (nxt_beat < X_BEATS) begin
            nxt_addr = ADDR_XKK_BASE + 32'(nxt_beat * 64);
            for (int l = 0; l < 8; l++) begin
                lin = nxt_beat * 8 + l;
                if (lin < STATE_DIM) begin
                    nxt_wdata[64*l +: 64] = x_src[IDX_W'(lin)];
                    nxt_wstrb[8*l +: 8]   = 8'hFF;
                end
            end
        end else begin
            nxt_addr = ADDR_PKK_BASE + 32'((nxt_beat - X_BEATS) * 64);
            for (int l = 0; l < 8; l++) begin
                lin = (nxt_beat - X_BEATS) * 8 + l;
                if (lin < STATE_DIM * STATE_DIM) begin
                    nxt_wdata[64*l +: 64] = p_snap[IDX_W'(lin / STATE_DIM)][IDX_W'(lin % STATE_DIM)];
                    nxt_wstrb[8*l +: 8]   = 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi_awaddr  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_snap      <= X_kk;
                        p_snap      <= P_kk;
                        beat_cnt    <= '0;
                        axi_awaddr  <= nxt_addr;
                        axi_wdata   <= nxt_wdata;
                        axi_wstrb   <= nxt_wstrb;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        busy        <= 1'b1;
                        wr_error    <= 1'b0;
                        state       <= S_ADDR_DATA;
                    end
                end
                S_ADDR_DATA: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        axi_bready <= 1'b1;
                        state      <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (bresp_err) begin
                            wr_error <= 1'b1;
                        end
                        if (last_beat || bresp_err) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            beat_cnt    <= beat_cnt + 1'b1;
                            axi_awaddr  <= nxt_addr;
                            axi_wdata   <= nxt_wdata;
                            axi_wstrb   <= nxt_wstrb;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= S_ADDR_DATA;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_writer_state_update.sv
// Self-checking bench for ddr4_writer_state_update: an AXI write slave with
// configurable/random ready and response delays captures every beat, and the
// captured memory image is compared with the image expected from the arrays
// present when start was accepted.

module tb_ddr4_writer_state_update;

    localparam int N     = 12;
    localparam int XB    = (N + 7) / 8;
    localparam int PB    = (N * N + 7) / 8;
    localparam int BEATS = XB + PB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [63:0]  X_kk [N];
    logic [63:0]  P_kk [N][N];
    logic [31:0]  axi_awaddr;
    logic [7:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic [1:0]   axi_awburst;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [511:0] axi_wdata;
    logic [63:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid;
    logic         axi_bready;
    logic         busy;
    logic         done;
    logic         wr_error;

    ddr4_writer_state_update dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X_kk(X_kk), .P_kk(P_kk),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .busy(busy), .done(done),
        .wr_error(wr_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    // reference copy of the arrays at the moment start is accepted
    logic [63:0] mx [N];
    logic [63:0] mp [N][N];

    // slave state
    logic [31:0]  aw_q [$];
    logic [511:0] wd_q [$];
    logic [63:0]  ws_q [$];
    int aw_cnt, w_cnt, b_issued, b_count, viol;
    int aw_delay, w_delay, b_delay, aw_wait, w_wait, b_wait;
    int err_beat = -1;
    int start_cyc, first_aw_cyc;
    bit rand_delay, b_drop, aw_pend, w_pend;
    logic [31:0]  aw_prev;
    logic [511:0] wd_prev;
    logic [63:0]  ws_prev;

    initial begin
        viol = 0; aw_delay = 0; w_delay = 0; b_delay = 0; rand_delay = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    end

    // Ready/response slave, driven at the falling edge so the DUT sees stable
    // values at the next rising edge. A handshake is recorded at the falling
    // edge that precedes the rising edge on which it completes.
    always @(negedge clk) begin
        if (!rst_n) begin
            axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
            b_drop = 0; aw_wait = 0; w_wait = 0; b_wait = 0; aw_pend = 0; w_pend = 0;
        end else begin
            if (b_drop) begin axi_bvalid = 0; b_drop = 0; end
            if (!axi_bvalid && aw_cnt > b_issued && w_cnt > b_issued) begin
                if (b_wait >= b_delay) begin
                    axi_bvalid = 1;
                    axi_bresp  = (b_issued == err_beat) ? 2'b10 : 2'b00;
                    b_issued++;
                    b_wait = 0;
                    if (rand_delay) b_delay = $urandom_range(0, 3);
                end else b_wait++;
            end
            if (axi_bvalid && axi_bready) begin b_count++; b_drop = 1; end

            if (axi_awvalid) begin
                if (aw_cnt > b_count) viol++;
                if (first_aw_cyc < 0) first_aw_cyc = cyc;
                if (aw_pend && axi_awaddr !== aw_prev) viol++;
                if (aw_wait >= aw_delay) begin
                    axi_awready = 1; aw_q.push_back(axi_awaddr); aw_cnt++; aw_wait = 0;
                    if (rand_delay) aw_delay = $urandom_range(0, 3);
                end else begin axi_awready = 0; aw_wait++; end
            end else begin axi_awready = 0; aw_wait = 0; end
            aw_pend = axi_awvalid && !axi_awready;
            aw_prev = axi_awaddr;

            if (axi_wvalid) begin
                if (w_cnt > b_count) viol++;
                if (w_pend && (axi_wdata !== wd_prev || axi_wstrb !== ws_prev)) viol++;
                if (w_wait >= w_delay) begin
                    axi_wready = 1; wd_q.push_back(axi_wdata); ws_q.push_back(axi_wstrb);
                    w_cnt++; w_wait = 0;
                    if (rand_delay) w_delay = $urandom_range(0, 3);
                end else begin axi_wready = 0; w_wait++; end
            end else begin axi_wready = 0; w_wait = 0; end
            w_pend  = axi_wvalid && !axi_wready;
            wd_prev = axi_wdata;
            ws_prev = axi_wstrb;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected beat b: X region first (elements 8b..8b+7), then P by linear
    // index row*N+col; lanes past the array end are zero with zero strobes.
    function automatic void exp_beat(input int b, output logic [31:0] a,
                                     output logic [511:0] d, output logic [63:0] s);
        int e;
        d = '0;
        s = '0;
        if (b < XB) begin
            a = 32'h0050_0000 + 32'(b * 64);
            for (int l = 0; l < 8; l++) begin
                e = b * 8 + l;
                if (e < N) begin d[64*l +: 64] = mx[e]; s[8*l +: 8] = 8'hFF; end
            end
        end else begin
            a = 32'h0060_0000 + 32'((b - XB) * 64);
            for (int l = 0; l < 8; l++) begin
                e = (b - XB) * 8 + l;
                if (e < N * N) begin d[64*l +: 64] = mp[e / N][e % N]; s[8*l +: 8] = 8'hFF; end
            end
        end
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) X_kk[i] = {$urandom, $urandom};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) P_kk[r][c] = {$urandom, $urandom};
    endtask

    task automatic slave_clear();
        aw_q.delete(); wd_q.delete(); ws_q.delete();
        aw_cnt = 0; w_cnt = 0; b_issued = 0; b_count = 0; first_aw_cyc = -1;
    endtask

    // Raise start, optionally disturb the inputs a cycle later, wait (bounded)
    // for done and report the latency in cycles from the start cycle.
    task automatic do_run(input bit change_inputs, input bit drop_start, output int lat);
        slave_clear();
        mx = X_kk;
        mp = P_kk;
        @(posedge clk); #1;
        start = 1;
        start_cyc = cyc;
        if (change_inputs) begin @(posedge clk); #1; randomize_inputs(); end
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            if (done === 1'b1) begin lat = cyc - start_cyc; break; end
            @(posedge clk); #1;
        end
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL done_timeout: done never rose, required within 3000 cycles");
        end
        if (drop_start) start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0;
        for (int i = 0; i < N; i++) X_kk[i] = '0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) P_kk[r][c] = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 9;
        if (axi_awvalid !== 1'b0) begin miscompares++; $display("FAIL rst_awvalid: got %b want 0", axi_awvalid); end
        if (axi_wvalid !== 1'b0) begin miscompares++; $display("FAIL rst_wvalid: got %b want 0", axi_wvalid); end
        if (axi_bready !== 1'b0) begin miscompares++; $display("FAIL rst_bready: got %b want 0", axi_bready); end
        if (axi_awaddr !== 32'h0) begin miscompares++; $display("FAIL rst_awaddr: got %h want 0", axi_awaddr); end
        if (axi_wdata !== 512'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", axi_wdata); end
        if (axi_wstrb !== 64'h0) begin miscompares++; $display("FAIL rst_wstrb: got %h want 0", axi_wstrb); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        if (wr_error !== 1'b0) begin miscompares++; $display("FAIL rst_wr_error: got %b want 0", wr_error); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        for (int i = 0; i < N; i++) X_kk[i] = 64'h1000 + 64'(i);
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) P_kk[r][c] = 64'(r * 16 + c);
        aw_delay = 0; w_delay = 0; b_delay = 0; rand_delay = 0;
        do_run(0, 1, lat);
        vectors += 6;
        if (lat != 2 * BEATS + 1) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", lat, 2 * BEATS + 1); end
        if (first_aw_cyc - start_cyc != 1) begin miscompares++; $display("FAIL basic_first_valid: got T+%0d want T+1", first_aw_cyc - start_cyc); end
        if (aw_q.size() != BEATS || wd_q.size() != BEATS) begin
            miscompares++; $display("FAIL basic_beats: got %0d/%0d want %0d", aw_q.size(), wd_q.size(), BEATS);
        end else begin
            if (ws_q[1] !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL basic_x1_strb: got %h want 00000000ffffffff", ws_q[1]); end
            if (aw_q[BEATS-1] !== 32'h0060_0440) begin miscompares++; $display("FAIL basic_last_addr: got %h want 00600440", aw_q[BEATS-1]); end
            for (int b = 0; b < BEATS; b++) begin
                exp_beat(b, ea, ed, es);
                vectors += 3;
                if (aw_q[b] !== ea) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h want %h", b, aw_q[b], ea); end
                if (wd_q[b] !== ed) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", b, wd_q[b], ed); end
                if (ws_q[b] !== es) begin miscompares++; $display("FAIL basic_strb[%0d]: got %h want %h", b, ws_q[b], es); end
            end
        end
        if (viol != 0) begin miscompares++; $display("FAIL basic_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_channel_skew();
        int lat;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        for (int m = 0; m < 2; m++) begin
            randomize_inputs();
            aw_delay = (m == 0) ? 3 : 0;
            w_delay  = (m == 0) ? 0 : 3;
            b_delay  = 0; rand_delay = 0;
            do_run(0, 1, lat);
            vectors += 3;
            if (b_count != BEATS) begin miscompares++; $display("FAIL skew%0d_bcount: got %0d want %0d", m, b_count, BEATS); end
            if (viol != 0) begin miscompares++; $display("FAIL skew%0d_protocol: got %0d violations want 0", m, viol); end
            if (aw_q.size() != BEATS || wd_q.size() != BEATS) begin
                miscompares++; $display("FAIL skew%0d_beats: got %0d/%0d want %0d", m, aw_q.size(), wd_q.size(), BEATS);
            end else begin
                for (int b = 0; b < BEATS; b++) begin
                    exp_beat(b, ea, ed, es);
                    vectors++;
                    if (aw_q[b] !== ea || wd_q[b] !== ed || ws_q[b] !== es) begin
                        miscompares++; $display("FAIL skew%0d_beat[%0d]: got addr %h strb %h want addr %h strb %h (or data differs)", m, b, aw_q[b], ws_q[b], ea, es);
                    end
                end
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_random_delays();
        int lat;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        for (int run = 0; run < 3; run++) begin
            randomize_inputs();
            rand_delay = 1;
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            do_run(0, 1, lat);
            vectors += 2;
            if (b_count != BEATS) begin miscompares++; $display("FAIL rand%0d_bcount: got %0d want %0d", run, b_count, BEATS); end
            if (aw_q.size() != BEATS || wd_q.size() != BEATS) begin
                miscompares++; $display("FAIL rand%0d_beats: got %0d/%0d want %0d", run, aw_q.size(), wd_q.size(), BEATS);
            end else begin
                for (int b = 0; b < BEATS; b++) begin
                    exp_beat(b, ea, ed, es);
                    vectors++;
                    if (aw_q[b] !== ea || wd_q[b] !== ed || ws_q[b] !== es) begin
                        miscompares++; $display("FAIL rand%0d_beat[%0d]: got addr %h strb %h want addr %h strb %h (or data differs)", run, b, aw_q[b], ws_q[b], ea, es);
                    end
                end
            end
        end
        rand_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        vectors++;
        if (viol != 0) begin miscompares++; $display("FAIL rand_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_snapshot();
        int lat;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        randomize_inputs();
        do_run(1, 1, lat);
        vectors++;
        if (wd_q.size() != BEATS) begin
            miscompares++; $display("FAIL snap_beats: got %0d want %0d", wd_q.size(), BEATS);
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                exp_beat(b, ea, ed, es);
                vectors++;
                if (wd_q[b] !== ed) begin miscompares++; $display("FAIL snap_data[%0d]: got %h want %h", b, wd_q[b], ed); end
            end
        end
    endtask

    task automatic test_start_held();
        int lat;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        randomize_inputs();
        do_run(0, 0, lat);
        repeat (10) @(posedge clk);
        #1;
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL held_done: got %b want 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL held_busy: got %b want 0", busy); end
        if (aw_q.size() != BEATS) begin miscompares++; $display("FAIL held_no_rerun: got %0d AW want %0d", aw_q.size(), BEATS); end
        start = 0;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL held_done_drop: got %b want 0", done); end
        randomize_inputs();
        do_run(0, 1, lat);
        vectors += 2;
        if (lat != 2 * BEATS + 1) begin miscompares++; $display("FAIL rerun_latency: got %0d want %0d", lat, 2 * BEATS + 1); end
        if (aw_q.size() != BEATS) begin
            miscompares++; $display("FAIL rerun_beats: got %0d want %0d", aw_q.size(), BEATS);
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                exp_beat(b, ea, ed, es);
                vectors++;
                if (aw_q[b] !== ea || wd_q[b] !== ed) begin miscompares++; $display("FAIL rerun_beat[%0d]: got addr %h want %h (or data differs)", b, aw_q[b], ea); end
            end
        end
    endtask

    task automatic test_bresp();
        int lat;
        randomize_inputs();
        err_beat = 5;
        do_run(0, 0, lat);
        err_beat = -1;
        vectors += 3;
`ifdef KALMAN_WR_BRESP_CHECK_EN
        if (lat != 2 * 6 + 1) begin miscompares++; $display("FAIL bresp_latency: got %0d want %0d", lat, 13); end
        if (aw_q.size() != 6) begin miscompares++; $display("FAIL bresp_aw_count: got %0d want 6", aw_q.size()); end
        if (wr_error !== 1'b1) begin miscompares++; $display("FAIL bresp_wr_error: got %b want 1", wr_error); end
        start = 0;
        do_run(0, 1, lat);
        vectors += 2;
        if (wr_error !== 1'b0) begin miscompares++; $display("FAIL bresp_clear: got %b want 0", wr_error); end
        if (aw_q.size() != BEATS) begin miscompares++; $display("FAIL bresp_clean_run: got %0d want %0d", aw_q.size(), BEATS); end
`else
        if (lat != 2 * BEATS + 1) begin miscompares++; $display("FAIL bresp_latency: got %0d want %0d", lat, 2 * BEATS + 1); end
        if (aw_q.size() != BEATS) begin miscompares++; $display("FAIL bresp_aw_count: got %0d want %0d", aw_q.size(), BEATS); end
        if (wr_error !== 1'b0) begin miscompares++; $display("FAIL bresp_wr_error: got %b want 0", wr_error); end
        start = 0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        logic [31:0] ea; logic [511:0] ed; logic [63:0] es;
        randomize_inputs();
        aw_delay = 3;
        slave_clear();
        @(posedge clk); #1;
        start = 1;
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (aw_cnt == 7 && axi_awvalid === 1'b1) begin seen = 1; break; end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL midrst_reach_beat7: beat 7 never offered"); end
        rst_n = 0;
        start = 0;
        @(posedge clk); #1;
        vectors += 5;
        if (axi_awvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_awvalid: got %b want 0", axi_awvalid); end
        if (axi_wvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_wvalid: got %b want 0", axi_wvalid); end
        if (axi_bready !== 1'b0) begin miscompares++; $display("FAIL midrst_bready: got %b want 0", axi_bready); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
        rst_n = 1;
        aw_delay = 0;
        randomize_inputs();
        do_run(0, 1, lat);
        vectors += 2;
        if (lat != 2 * BEATS + 1) begin miscompares++; $display("FAIL midrst_latency: got %0d want %0d", lat, 2 * BEATS + 1); end
        if (aw_q.size() != BEATS) begin
            miscompares++; $display("FAIL midrst_beats: got %0d want %0d", aw_q.size(), BEATS);
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                exp_beat(b, ea, ed, es);
                vectors++;
                if (aw_q[b] !== ea || wd_q[b] !== ed || ws_q[b] !== es) begin
                    miscompares++; $display("FAIL midrst_beat[%0d]: got addr %h want %h (or data/strb differs)", b, aw_q[b], ea);
                end
            end
        end
        if (viol != 0) begin miscompares++; $display("FAIL midrst_protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channel_skew();
        test_random_delays();
        test_snapshot();
        test_start_held();
        test_bresp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr4_writer_state_update.md
# ddr4_writer_state_update

Writes the Kalman filter's updated state vector X_kk and covariance P_kk back to DDR4 over a 512-bit AXI write port, one single-beat burst at a time. It sits directly downstream of the measurement-update stage and mirrors the initial-parameter reader: same 8-elements-per-beat packing, row-major P layout, and a start/done level handshake. On `start` it snapshots both arrays, so the upstream stage may begin the next iteration while the write-back is still running.

## Interface
- STATE_DIM, 12, state dimension N.
- ADDR_XKK_BASE, 32'h0050_0000, byte base address of the X_kk region.
- ADDR_PKK_BASE, 32'h0060_0000, byte base address of the P_kk region.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  level request; sampled only in IDLE.
- X_kk  in  64×N  state vector; element i is 64-bit.
- P_kk  in  64×N×N  covariance matrix, indexed [row][col].
- axi_awaddr  out  32  write address.
- axi_awlen  out  8  constant 0 (single beat).
- axi_awsize  out  3  constant 3'b110 (64 B).
- axi_awburst  out  2  constant 2'b01 (INCR).
- axi_awvalid / axi_awready  out / in  1  address handshake.
- axi_wdata  out  512  beat data.
- axi_wstrb  out  64  byte strobes.
- axi_wlast  out  1  constant 1.
- axi_wvalid / axi_wready  out / in  1  data handshake.
- axi_bresp  in  2  write response.
- axi_bvalid / axi_bready  in / out  1  response handshake.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  level; high in DONE.
- wr_error  out  1  sticky response error (see Configuration).

## Operation
- X_BEATS = ceil(N/8); P_BEATS = ceil(N²/8). For N=12 these are 2 and 18, giving 20 beats in total.
- Beat b of X carries elements 8b..8b+7; element i of the beat goes in wdata[64i +: 64]. P uses the linear index lin = row·N + col and the same packing.
- Lanes past the end of the array: wdata lane = 0 and the 8 strobe bits of that lane = 0. All other strobes = 1. For N=12, X beat 1 has wstrb = 64'h0000_0000_FFFF_FFFF; every P beat has all strobes set.
- Beat address = base + b·64.
- States:
  - IDLE: if start, snapshot X_kk/P_kk into internal registers, load X beat 0, go to ADDR_DATA.
  - ADDR_DATA: awvalid and wvalid asserted together. Each one is held until its own handshake completes; flags aw_done and w_done track this, and the channels may accept in either order or in the same cycle. When both are done, go to WAIT_B.
  - WAIT_B: bready = 1. On bvalid, go to the next beat (X beats, then P beats, then DONE) and re-enter ADDR_DATA.
  - DONE: done = 1, busy = 0. When start is low, go to IDLE.
- start is ignored outside IDLE. Input array changes after the snapshot have no effect.
- Only one transaction is outstanding at any time.

## Timing
- Reset values: awvalid = 0, wvalid = 0, bready = 0, awaddr = 0, wdata = 0, wstrb = 0, busy = 0, done = 0, wr_error = 0, state = IDLE.
- start high in cycle T means awvalid and wvalid are high in T+1.
- With ready and bvalid returned immediately, each beat takes 2 cycles: AW/W handshake in cycle n, B handshake in n+1, next AW/W in n+2.
- done rises the cycle after the final B handshake. For N=12 with zero-wait slaves, done is high at T+41.
- awaddr, wdata and wstrb stay stable while the corresponding valid is high and not yet accepted.
- bready is low outside WAIT_B. A bvalid seen outside WAIT_B is not consumed.
- Reset asserted mid-transfer: next edge returns to reset values. No cleanup of the in-flight AXI transaction; the system resets the slave at the same time.

## Configuration
- KALMAN_WR_BRESP_CHECK_EN defined:
  - bresp ≠ 2'b00 during a B handshake sets wr_error.
  - The remaining beats are skipped and the block goes straight to DONE.
  - wr_error clears on the next accepted start.
- Not defined: bresp is ignored, all beats are written, and wr_error is tied to 0.

## Test plan
- N=12, X[i] = 64'h1000+i, P[r][c] = r·16+c, always-ready slave → 20 writes, at addresses 0x0050_0000, 0x0050_0040, then 0x0060_0000 through 0x0060_0440; X beat 1 has lanes 4–7 = 0 and wstrb = 64'h0000_0000_FFFF_FFFF; done at T+41.
- awready delayed 3 cycles while wready is immediate (and the reverse) → wvalid drops after its own handshake, awvalid stays held, exactly one B per beat, data unchanged.
- Inputs changed one cycle after start → memory image equals the values present at start.
- start held high through DONE → no second run; drop start, raise it again → a new 20-beat run.
- With the macro defined, bresp = 2'b10 on beat 5 → wr_error = 1, no further AW issued, done next cycle. Without the macro → all 20 beats are written and wr_error = 0.
- rst_n low mid-beat 7 → next cycle all valids and busy are 0, state is IDLE; a new start then runs from beat 0.
